// File: rtl/cla_result_checker.sv
// Response checker for a W-bit carry-lookahead adder: recomputes {c_out,sum}
// from each accepted tuple, compares it with the adder's result and keeps run statistics.
module cla_result_checker #(
    parameter int W           = 4,
    parameter int NUM_VECTORS = 20,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             c_in,
    input  logic [W-1:0]     sum,
    input  logic             c_out,
    output logic             err_pulse,
    output logic             done,
    output logic             all_pass,
    output logic [IDX_W-1:0] pass_cnt,
    output logic [IDX_W-1:0] fail_cnt,
    output logic [IDX_W-1:0] fail_idx,
    output logic [W:0]       fail_exp,
    output logic [W:0]       fail_got
);

    typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] NUM_V    = IDX_W'(NUM_VECTORS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_t             state;
    state_t             state_nxt;
    logic               enter_check;
    logic               accept;
    logic [IDX_W-1:0]   acc_cnt;
    logic               first_seen;

    logic               vld_p1;
    logic [W:0]         exp_p1;
    logic [W:0]         got_p1;
    logic [IDX_W-1:0]   idx_p1;

    logic               vld_p2;
    logic               mis_p2;
    logic [W:0]         exp_p2;
    logic [W:0]         got_p2;
    logic [IDX_W-1:0]   idx_p2;

    // Golden sum at W+1 bits so the carry lands in the MSB.
    function automatic logic [W:0] golden_sum(input logic [W-1:0] op_a,
                                              input logic [W-1:0] op_b,
                                              input logic         cin);
        return {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == {IDX_W{1'b1}}) ? v : v + IDX_W'(1);
    endfunction

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        enter_check = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = CHECK;
                    enter_check = 1'b1;
                end
            end
            CHECK: begin
                in_ready = (acc_cnt < NUM_V);
                if (in_valid && in_ready && (acc_cnt == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p1 && !vld_p2) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt   = CHECK;
                    enter_check = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign done     = (state == DONE);
    assign all_pass = done && (fail_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (enter_check) begin
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + IDX_W'(1);
            end
        end
    end

    // Stage 1: capture received result, index and golden result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            exp_p1 <= golden_sum(a, b, c_in);
            got_p1 <= {c_out, sum};
            idx_p1 <= acc_cnt;
        end
    end

    // Stage 2: compare
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mis_p2 <= (exp_p1 != got_p1);
            exp_p2 <= exp_p1;
            got_p2 <= got_p1;
            idx_p2 <= idx_p1;
        end
    end

    // Result update: pulse, counters, first-mismatch capture
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_idx   <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            first_seen <= 1'b0;
        end else if (enter_check) begin
            err_pulse  <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_idx   <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            first_seen <= 1'b0;
        end else begin
            err_pulse <= vld_p2 && mis_p2;
            if (vld_p2) begin
                if (mis_p2) begin
                    fail_cnt <= sat_inc(fail_cnt);
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        fail_idx   <= idx_p2;
                        fail_exp   <= exp_p2;
                        fail_got   <= got_p2;
                    end
                end else begin
                    pass_cnt <= sat_inc(pass_cnt);
                end
            end
        end
    end

endmodule
